// File: rtl/pix_capture_pkg.sv
// Shared types and pixel packing helper for the camera capture path.
package pix_capture_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2,
        FRAME_END  = 2'd3
    } cap_state_t;

    typedef enum logic {
        MODE_RGB444 = 1'b0,
        MODE_RGB565 = 1'b1
    } pix_mode_t;

    // Builds one pixel from the two camera bytes. The result is 16 bits wide;
    // a 12-bit output uses the low 12 bits. RGB565 squeezed into 12 bits keeps
    // the top four bits of each channel: R[4:1], G[5:2], B[4:1].
    function automatic logic [15:0] pack_pixel(input pix_mode_t  mode,
                                               input logic [7:0] byte0,
                                               input logic [7:0] byte1,
                                               input int         pix_w);
        logic [15:0] pix;
        case (mode)
            MODE_RGB444: pix = {4'h0, byte0[3:0], byte1};
            MODE_RGB565: begin
                if (pix_w == 32'sd12) begin
                    pix = {4'h0, byte0[7:4], byte0[2:0], byte1[7], byte1[4:1]};
                end else begin
                    pix = {byte0, byte1};
                end
            end
            default:     pix = 16'h0000;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/pix_capture_pl_sync.sv
// Camera input register stage with vsync/href edge detection.
// Edge strobes are decoded from two register stages so downstream logic only
// ever sees registered camera signals.
module pix_byte_sync
    import pix_capture_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_pix_byte,
    input  logic       i_pix_vsync,
    input  logic       i_pix_href,
    output logic [7:0] o_byte,
    output logic       o_href,
    output logic       o_vsync_fall,
    output logic       o_vsync_rise,
    output logic       o_href_fall
);

    logic [7:0] byte_r;
    logic       vsync_r;
    logic       href_r;
    logic       vsync_d_r;
    logic       href_d_r;

    // Register the camera bus once, then keep a delayed copy for edge detect.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_r    <= 8'h00;
            vsync_r   <= 1'b0;
            href_r    <= 1'b0;
            vsync_d_r <= 1'b0;
            href_d_r  <= 1'b0;
        end else begin
            byte_r    <= i_pix_byte;
            vsync_r   <= i_pix_vsync;
            href_r    <= i_pix_href;
            vsync_d_r <= vsync_r;
            href_d_r  <= href_r;
        end
    end

    assign o_byte       = byte_r;
    assign o_href       = href_r;
    assign o_vsync_fall = vsync_d_r & ~vsync_r;
    assign o_vsync_rise = ~vsync_d_r & vsync_r;
    assign o_href_fall  = href_d_r & ~href_r;

endmodule

// File: rtl/pix_capture_pl.sv
// Parametrised OV7670 capture: assembles two-byte pixels (RGB444/RGB565),
// generates sequential frame-buffer write addresses and flags line-length,
// frame-size and overflow errors. Single clock domain (camera PCLK).
// Optional build macro PIX_CAPTURE_DECIM_EN adds i_decim: 2x2 decimation
// writing only even pixels of even lines into a packed address range.
module pix_capture_pl
    import pix_capture_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int PIX_W  = 16,
    parameter int ADDR_W = 19
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_mode,
    input  logic [7:0]        i_pix_byte,
    input  logic              i_pix_vsync,
    input  logic              i_pix_href,
`ifdef PIX_CAPTURE_DECIM_EN
    input  logic              i_decim,
`endif
    output logic              o_pix_wr,
    output logic [ADDR_W-1:0] o_pix_addr,
    output logic [PIX_W-1:0]  o_pix_data,
    output logic              o_frame_done,
    output logic [7:0]        o_frame_cnt,
    output logic              o_err_line,
    output logic              o_err_frame,
    output logic              o_err_ovf
);

    // One spare bit so the address can reach WIDTH*HEIGHT even when that
    // equals 2^ADDR_W; a second spare bit gives the frame counter headroom.
    localparam int CNT_W = ADDR_W + 2;
    localparam logic [CNT_W-1:0] FULL_LIMIT  = CNT_W'(WIDTH * HEIGHT);
    localparam logic [CNT_W-1:0] DECIM_LIMIT = CNT_W'((WIDTH / 2) * (HEIGHT / 2));
    localparam logic [15:0]      LINE_LEN    = 16'(WIDTH);

    logic [7:0]  byte_s;
    logic        href_s;
    logic        vsync_fall_s;
    logic        vsync_rise_s;
    logic        href_fall_s;
    logic [15:0] pix_s;
    logic        keep_s;
    logic [CNT_W-1:0] limit_s;

    cap_state_t       state_r;
    pix_mode_t        mode_r;
    logic             phase_r;
    logic [7:0]       hold_r;
    logic [CNT_W-1:0] addr_r;
    logic [CNT_W-1:0] frame_pix_r;
    logic [15:0]      line_pix_r;
    logic [15:0]      line_cnt_r;
`ifdef PIX_CAPTURE_DECIM_EN
    logic             decim_r;
`endif

    pix_byte_sync u_sync (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pix_byte   (i_pix_byte),
        .i_pix_vsync  (i_pix_vsync),
        .i_pix_href   (i_pix_href),
        .o_byte       (byte_s),
        .o_href       (href_s),
        .o_vsync_fall (vsync_fall_s),
        .o_vsync_rise (vsync_rise_s),
        .o_href_fall  (href_fall_s)
    );

    // Pixel assembly plus the per-frame write filter and size target.
    always_comb begin
        pix_s = pack_pixel(mode_r, hold_r, byte_s, PIX_W);
`ifdef PIX_CAPTURE_DECIM_EN
        keep_s  = ~decim_r | (~line_pix_r[0] & ~line_cnt_r[0]);
        limit_s = decim_r ? DECIM_LIMIT : FULL_LIMIT;
`else
        keep_s  = 1'b1;
        limit_s = FULL_LIMIT;
`endif
    end

    // Capture FSM with registered write port, frame pulse and sticky errors.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= IDLE;
            mode_r       <= MODE_RGB444;
            phase_r      <= 1'b0;
            hold_r       <= 8'h00;
            addr_r       <= '0;
            frame_pix_r  <= '0;
            line_pix_r   <= 16'd0;
            line_cnt_r   <= 16'd0;
`ifdef PIX_CAPTURE_DECIM_EN
            decim_r      <= 1'b0;
`endif
            o_pix_wr     <= 1'b0;
            o_pix_addr   <= '0;
            o_pix_data   <= '0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= 8'd0;
            o_err_line   <= 1'b0;
            o_err_frame  <= 1'b0;
            o_err_ovf    <= 1'b0;
        end else begin
            o_pix_wr     <= 1'b0;
            o_frame_done <= 1'b0;
            if (!i_en) begin
                state_r <= IDLE;
            end else begin
                case (state_r)
                    IDLE: state_r <= WAIT_FRAME;
                    WAIT_FRAME: begin
                        if (vsync_fall_s) begin
                            mode_r      <= pix_mode_t'(i_mode);
                            addr_r      <= '0;
                            frame_pix_r <= '0;
                            line_pix_r  <= 16'd0;
                            line_cnt_r  <= 16'd0;
                            phase_r     <= 1'b0;
`ifdef PIX_CAPTURE_DECIM_EN
                            decim_r     <= i_decim;
`endif
                            state_r     <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (href_s) begin
                            if (!phase_r) begin
                                hold_r  <= byte_s;
                                phase_r <= 1'b1;
                            end else begin
                                phase_r    <= 1'b0;
                                line_pix_r <= line_pix_r + 16'd1;
                                if (keep_s) begin
                                    if (frame_pix_r != {CNT_W{1'b1}}) begin
                                        frame_pix_r <= frame_pix_r + {{(CNT_W-1){1'b0}}, 1'b1};
                                    end
                                    if (addr_r == limit_s) begin
                                        o_err_ovf <= 1'b1;
                                    end else begin
                                        o_pix_wr   <= 1'b1;
                                        o_pix_addr <= addr_r[ADDR_W-1:0];
                                        o_pix_data <= pix_s[PIX_W-1:0];
                                        addr_r     <= addr_r + {{(CNT_W-1){1'b0}}, 1'b1};
                                    end
                                end
                            end
                        end else if (href_fall_s && !vsync_rise_s) begin
                            // Odd byte count or wrong pixel count both mark the line bad.
                            if (phase_r || (line_pix_r != LINE_LEN)) begin
                                o_err_line <= 1'b1;
                            end
                            phase_r    <= 1'b0;
                            line_pix_r <= 16'd0;
                            line_cnt_r <= line_cnt_r + 16'd1;
                        end
                        // A write in the same cycle still completes before frame end.
                        if (vsync_rise_s) begin
                            state_r <= FRAME_END;
                        end
                    end
                    FRAME_END: begin
                        o_frame_done <= 1'b1;
                        o_frame_cnt  <= o_frame_cnt + 8'd1;
                        if (frame_pix_r != limit_s) begin
                            o_err_frame <= 1'b1;
                        end
                        state_r <= WAIT_FRAME;
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pix_capture_pl.sv
// Self-checking bench for pix_capture_pl (WIDTH=8, HEIGHT=4, ADDR_W=5).
// Two instances share the stimulus: PIX_W=16 and PIX_W=12.
module tb_pix_capture_pl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 5;

    typedef struct {
        int addr;
        int d16;
        int d12;
        int cyc;
    } wr_t;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_en = 1'b0;
    logic       i_mode = 1'b0;
    logic [7:0] i_pix_byte = 8'h00;
    logic       i_pix_vsync = 1'b0;
    logic       i_pix_href = 1'b0;
`ifdef PIX_CAPTURE_DECIM_EN
    logic       i_decim = 1'b0;
`endif

    logic          wr_a, done_a, el_a, ef_a, eo_a;
    logic [AW-1:0] addr_a;
    logic [15:0]   data_a;
    logic [7:0]    fcnt_a;
    logic          wr_b, done_b, el_b, ef_b, eo_b;
    logic [AW-1:0] addr_b;
    logic [11:0]   data_b;
    logic [7:0]    fcnt_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int exp_done = 0;

    wr_t exp_q[$];
    int  e_addr, e_fpix, e_mode, e_fcnt;
    bit  e_line, e_frame, e_ovf;
    bit  use_fix;
    int  fix_b0, fix_b1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pix_capture_pl #(.WIDTH(W), .HEIGHT(H), .PIX_W(16), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode),
        .i_pix_byte(i_pix_byte), .i_pix_vsync(i_pix_vsync), .i_pix_href(i_pix_href),
`ifdef PIX_CAPTURE_DECIM_EN
        .i_decim(i_decim),
`endif
        .o_pix_wr(wr_a), .o_pix_addr(addr_a), .o_pix_data(data_a),
        .o_frame_done(done_a), .o_frame_cnt(fcnt_a),
        .o_err_line(el_a), .o_err_frame(ef_a), .o_err_ovf(eo_a)
    );

    pix_capture_pl #(.WIDTH(W), .HEIGHT(H), .PIX_W(12), .ADDR_W(AW)) dut12 (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode),
        .i_pix_byte(i_pix_byte), .i_pix_vsync(i_pix_vsync), .i_pix_href(i_pix_href),
`ifdef PIX_CAPTURE_DECIM_EN
        .i_decim(i_decim),
`endif
        .o_pix_wr(wr_b), .o_pix_addr(addr_b), .o_pix_data(data_b),
        .o_frame_done(done_b), .o_frame_cnt(fcnt_b),
        .o_err_line(el_b), .o_err_frame(ef_b), .o_err_ovf(eo_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference pixel values from the channel arithmetic.
    function automatic int m16(input int mode, input int b0, input int b1);
        return (mode != 0) ? (b0 * 256 + b1) : ((b0 % 16) * 256 + b1);
    endfunction

    function automatic int m12(input int mode, input int b0, input int b1);
        int r, g, b;
        if (mode == 0) return (b0 % 16) * 256 + b1;
        r = b0 / 8;
        g = (b0 % 8) * 8 + b1 / 32;
        b = b1 % 32;
        return (r / 2) * 256 + (g / 4) * 16 + (b / 2);
    endfunction

    // Write monitor: every strobe must match the next expected write.
    always @(negedge clk) begin
        wr_t e;
        if (done_a === 1'b1) done_cnt++;
        if (wr_a === 1'b1 || wr_b === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'(wr_a), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr16", 32'(wr_a), 32'd1);
                chk("wr12", 32'(wr_b), 32'd1);
                chk("addr16", 32'(addr_a), 32'(e.addr));
                chk("addr12", 32'(addr_b), 32'(e.addr));
                chk("data16", 32'(data_a), 32'(e.d16));
                chk("data12", 32'(data_b), 32'(e.d12));
                chk("wr_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic model_pixel(input int b0, input int b1, input int c);
        e_fpix++;
        if (e_addr < W * H) begin
            exp_q.push_back('{e_addr, m16(e_mode, b0, b1), m12(e_mode, b0, b1), c + 2});
            e_addr++;
        end else begin
            e_ovf = 1'b1;
        end
    endtask

    task automatic start_frame(input int mode);
        i_mode = 1'(mode);
        i_pix_vsync = 1'b1;
        repeat (3) @(negedge clk);
        i_pix_vsync = 1'b0;
        e_mode = mode;
        e_addr = 0;
        e_fpix = 0;
        repeat (3) @(negedge clk);
        i_mode = ~i_mode;
    endtask

    task automatic send_line(input int nbytes, input bit abort);
        int b0 = 0;
        int b;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            if (use_fix) b = (i % 2 == 0) ? fix_b0 : fix_b1;
            else b = int'($urandom_range(255, 0));
            i_pix_byte = 8'(b);
            i_pix_href = 1'b1;
            if (abort && i == nbytes - 1) i_pix_vsync = 1'b1;
            if (i % 2 == 0) b0 = b;
            else model_pixel(b0, b, cyc);
        end
        @(negedge clk);
        i_pix_href = 1'b0;
        repeat (3) @(negedge clk);
        if (!abort && ((nbytes % 2) != 0 || (nbytes / 2) != W)) e_line = 1'b1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
        chk({tag, "_fcnt16"}, 32'(fcnt_a), 32'(e_fcnt % 256));
        chk({tag, "_fcnt12"}, 32'(fcnt_b), 32'(e_fcnt % 256));
        chk({tag, "_err_line"}, 32'(el_a), 32'(e_line));
        chk({tag, "_err_frame"}, 32'(ef_a), 32'(e_frame));
        chk({tag, "_err_ovf"}, 32'(eo_a), 32'(e_ovf));
        chk({tag, "_err12"}, {29'd0, el_b, ef_b, eo_b}, {29'd0, e_line, e_frame, e_ovf});
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic end_frame(input string tag);
        @(negedge clk);
        i_pix_vsync = 1'b1;
        repeat (4) @(negedge clk);
        if (e_fpix != W * H) e_frame = 1'b1;
        e_fcnt++;
        exp_done++;
        check_state(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        chk("rst_wr", {31'd0, wr_a | wr_b}, 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_done", {31'd0, done_a | done_b}, 32'd0);
        chk("rst_fcnt", 32'(fcnt_a), 32'd0);
        chk("rst_errs", {29'd0, el_a, ef_a, eo_a}, 32'd0);
        chk("rst_errs12", {29'd0, el_b, ef_b, eo_b}, 32'd0);
        i_rst = 1'b0;
        chk("rst_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        e_line = 1'b0;
        e_frame = 1'b0;
        e_ovf = 1'b0;
        e_fcnt = 0;
    endtask

    initial begin
        e_fcnt = 0;
        do_reset();
        i_en = 1'b1;
        repeat (2) @(negedge clk);

        // RGB444, fixed F1/23
        use_fix = 1'b1; fix_b0 = 8'hF1; fix_b1 = 8'h23;
        start_frame(0);
        for (int l = 0; l < H; l++) send_line(2 * W, 1'b0);
        end_frame("rgb444");

        // RGB565, fixed F8/1F
        fix_b0 = 8'hF8; fix_b1 = 8'h1F;
        start_frame(1);
        for (int l = 0; l < H; l++) send_line(2 * W, 1'b0);
        end_frame("rgb565");

        // Random bytes and mode, clean frame
        use_fix = 1'b0;
        start_frame(int'($urandom_range(1, 0)));
        for (int l = 0; l < H; l++) send_line(2 * W, 1'b0);
        end_frame("rand_clean");

        // Line 2 short by one pixel
        start_frame(int'($urandom_range(1, 0)));
        for (int l = 0; l < H; l++) send_line((l == 2) ? 2 * W - 2 : 2 * W, 1'b0);
        end_frame("short_line");

        // Next frame restarts at address 0
        start_frame(int'($urandom_range(1, 0)));
        for (int l = 0; l < H; l++) send_line(2 * W, 1'b0);
        end_frame("restart");

        // Reset mid-frame; bytes afterwards must not be captured
        start_frame(0);
        send_line(2 * W, 1'b0);
        send_line(2 * W, 1'b0);
        do_reset();
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            i_pix_byte = 8'($urandom_range(255, 0));
            i_pix_href = 1'b1;
        end
        @(negedge clk);
        i_pix_href = 1'b0;
        i_pix_vsync = 1'b1;
        repeat (5) @(negedge clk);
        check_state("post_rst_idle");

        start_frame(int'($urandom_range(1, 0)));
        for (int l = 0; l < H; l++) send_line(2 * W, 1'b0);
        end_frame("post_rst_frame");

        // Five lines: overflow
        start_frame(int'($urandom_range(1, 0)));
        for (int l = 0; l < H + 1; l++) send_line(2 * W, 1'b0);
        end_frame("overflow");

        // Random line lengths including odd byte counts
        do_reset();
        start_frame(int'($urandom_range(1, 0)));
        for (int l = 0; l < H; l++) send_line(int'($urandom_range(17, 13)), 1'b0);
        end_frame("rand_len");

        // vsync rises with the last byte of a partial line
        do_reset();
        start_frame(int'($urandom_range(1, 0)));
        for (int l = 0; l < H - 1; l++) send_line(2 * W, 1'b0);
        send_line(6, 1'b1);
        end_frame("abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pix_capture_pl.md
Name: pix_capture_pl

Overview:
- Parametrised successor to the fixed 640x480 RGB444 OV7670 capture path.
- Samples the camera byte stream (byte, vsync, href), assembles two-byte pixels in RGB444 or RGB565 mode and generates sequential frame-buffer write addresses.
- Flags line-length, frame-size and overflow errors.
- Sits between the camera interface and the pixel BRAM, entirely in the PCLK domain.

Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- PIX_W, 16, output pixel width; 12 or 16 only
- ADDR_W, 19, write address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
- i_clk  in  1  pixel clock (PCLK domain); the only clock
- i_rst  in  1  synchronous reset, active-high
- i_en  in  1  capture enable; typically tied to camera-init done
- i_mode  in  1  0 = RGB444, 1 = RGB565; sampled only at frame start
- i_pix_byte  in  8  camera data byte
- i_pix_vsync  in  1  camera vsync; high = vertical blanking
- i_pix_href  in  1  camera href; high = valid byte
- o_pix_wr  out  1  one-cycle BRAM write strobe
- o_pix_addr  out  ADDR_W  write address
- o_pix_data  out  PIX_W  assembled pixel
- o_frame_done  out  1  one-cycle pulse at frame end
- o_frame_cnt  out  8  completed frames; wraps 255 -> 0
- o_err_line  out  1  sticky: a line did not carry 2*WIDTH bytes
- o_err_frame  out  1  sticky: frame ended with pixel count != WIDTH*HEIGHT
- o_err_ovf  out  1  sticky: a write was suppressed because the address reached WIDTH*HEIGHT

Behaviour:
- Input registration: i_pix_byte, i_pix_vsync and i_pix_href each pass through one register stage. All decisions use the registered values.
- Edge detection: vsync_fall and vsync_rise, href_fall, taken from the registered values.
- Reset values: all outputs 0; FSM in IDLE; byte phase 0; mode register 0.
- FSM IDLE: stay while i_en = 0; go to WAIT_FRAME when i_en = 1.
- FSM WAIT_FRAME: ignore href; on vsync_fall, latch i_mode, clear address, line pixel count, line count and byte phase, then go to ACTIVE.
- FSM ACTIVE: capture pixels while href = 1.
  - Byte phase 0: hold the byte in a holding register.
  - Byte phase 1: assemble the pixel and write it.
- FSM ACTIVE, on vsync_rise: go to FRAME_END.
- FSM FRAME_END: one cycle; pulse o_frame_done; increment o_frame_cnt; set o_err_frame if pixel count != WIDTH*HEIGHT; go to WAIT_FRAME.
- i_en = 0 in any state: return to IDLE next cycle. Sticky flags and o_frame_cnt are kept.
- Pixel packing, RGB444: pixel = {byte0[3:0], byte1}, 12 bits.
- Pixel packing, RGB565: pixel = {byte0, byte1}, 16 bits.
- Width rule, PIX_W = 12 with RGB565: take the top 4 bits of each channel, {R[4:1], G[5:2], B[4:1]}.
- Width rule, PIX_W = 16 with RGB444: zero-extend on the left.
- Latency: o_pix_wr is high exactly 2 cycles after the second byte is present on the inputs. o_pix_addr and o_pix_data are valid in the same cycle.
- Address: post-increments after each write and starts at 0 every frame.
- Overflow: once the address equals WIDTH*HEIGHT, further writes are suppressed (o_pix_wr stays 0), o_err_ovf is set and the address holds.
- href_fall in ACTIVE:
  - If byte phase = 1 (odd byte count), drop the partial byte and set o_err_line.
  - If the line's pixel count != WIDTH, set o_err_line.
  - Reset byte phase and line pixel count; increment line count.
- vsync_rise in the same cycle as a write: the write completes, and FRAME_END then counts that pixel.
- vsync_rise mid-line: the partial line aborts without setting o_err_line; o_err_frame is evaluated as normal.
- Sticky error flags clear only on i_rst.

Optional Feature:
- Macro: PIX_CAPTURE_DECIM_EN.
- When defined:
  - Adds input i_decim (1 bit), sampled at frame start.
  - With i_decim = 1, only even pixels of even lines are written.
  - Addresses are packed 0 .. (WIDTH/2)*(HEIGHT/2) - 1.
  - o_err_frame compares against (WIDTH/2)*(HEIGHT/2).
- When undefined: no port is added and all pixels are written.

Decomposition:
- Package pix_capture_pkg holds:
  - typedef enum {IDLE, WAIT_FRAME, ACTIVE, FRAME_END} cap_state_t
  - typedef enum {MODE_RGB444, MODE_RGB565} pix_mode_t
  - function pack_pixel(mode, byte0, byte1, pix_w)
- One natural sub-module, pix_byte_sync: the input register stage plus vsync/href edge detectors.

Test Plan (WIDTH = 8, HEIGHT = 4 unless stated):
- RGB444 frame, bytes F1/23 repeated -> 32 writes, data 0x0123, addresses 0..31 in order; o_frame_done pulses once; o_frame_cnt = 1; no error flags.
- RGB565 frame with PIX_W = 12, bytes F8/1F -> every pixel 0xF0F (R = 0x1F -> 0xF, G = 0x00 -> 0x0, B = 0x1F -> 0xF).
- Line 2 carries 7 pixels -> o_err_line = 1; 31 writes; o_err_frame = 1 at frame end; next frame restarts at address 0.
- 5 lines of 8 pixels -> writes stop after address 31; o_err_ovf = 1; o_err_frame = 1.
- i_rst asserted mid-frame -> all outputs 0 next cycle; capture resumes only after a fresh vsync_fall.
- PIX_CAPTURE_DECIM_EN defined, i_decim = 1 -> 8 writes at addresses 0..7 containing pixels 0, 2, 4, 6 of lines 0 and 2; no error flags.
